conv_sched: RTL and testbench
=============================

// Module: conv_sched
// PURPOSE
// Sequencer for the conv_2D MAC datapath (mem_x, mem_h, mem_y, accumulator f).
// After image and kernel are loaded, sweeps every valid output position of an X*X image with an H*H kernel.
// Per position it issues the H*H tap addresses, frames accumulation, and commits the sum to mem_y.
// Sits between the load/stream FSM (start/done handshake) and the datapath address/enable pins.
// PARAMETERS
// X      5   image width = height, pixels; X*X <= 16384
// H      3   kernel width = height; 1 <= H <= X; H*H <= 256
// PORTS
// clk        in   1   rising-edge clock
// reset      in   1   asynchronous, active-high; forces IDLE
// start      in   1   begin a sweep; sampled only in IDLE
// hold       in   1   freeze all state and pipeline regs this cycle (downstream stall)
// busy       out  1   high from the cycle after start is accepted until done
// done       out  1   one-cycle pulse after the final mem_y write
// addr_x     out  14  mem_x read address
// addr_h     out  8   mem_h read address
// acc_en     out  1   accumulate the current mem_x/mem_h read data into f
// acc_first  out  1   with acc_en: load f <= product (clears the previous sum)
// addr_y     out  14  mem_y write address
// wr_en_y    out  1   write f into mem_y[addr_y]
// BEHAVIOUR
// - Reset: all outputs 0; counters 0; state IDLE; pipeline valids cleared. Asserting reset mid-sweep aborts it with no further writes.
// - OUT = X-H+1 outputs per side; OUT*OUT outputs, H*H taps each.
// - Counters: orow, ocol in [0,OUT-1]; kr, kc in [0,H-1].
//   kc is the fastest, then kr, then ocol, then orow.
// - Issue stage (RUN, !hold): addr_x = (orow+kr)*X + (ocol+kc) and addr_h = kr*H + kc, both registered.
//   One tap per cycle, no bubbles between positions.
// - Memory read latency is 1 cycle, so the tap valid is delayed 1 stage.
//   acc_en is asserted the cycle after the address is presented.
//   acc_first accompanies acc_en for tap kr=kc=0.
// - Commit stage: wr_en_y asserts 1 cycle after acc_en of the last tap (kr=kc=H-1), i.e. after f holds the complete sum.
//   addr_y = orow*OUT + ocol of that position.
//   addr_y advances by exactly 1 per write; it is 0 for the first write.
// - FSM:
//   IDLE  -> RUN   on start.
//   RUN   -> DRAIN after the last tap is issued.
//   DRAIN -> DONE  when the pipeline is empty (2 cycles after the last issue).
//   DONE  -> IDLE  unconditionally (done=1 for this single cycle).
// - start while not IDLE is ignored. start together with hold in IDLE is held off until hold drops.
// - hold: freezes counters, FSM, addresses and pipeline valids. acc_en and wr_en_y are forced 0 during hold.
//   Frozen enables re-assert when hold drops, so no tap or write is lost or duplicated.
// - H==1: each position is a single tap with acc_first=1. addr_x == addr_y for every output.
// - Widths: address arithmetic is unsigned, computed in 14 bits; parameter limits guarantee no overflow.
// STRUCTURE
// - conv_pkg holds: the state enum (IDLE, RUN, DRAIN, DONE), localparams OUT = X-H+1 and NOUT = OUT*OUT, and the address widths AW_X=14, AW_H=8.
// - One sub-module, conv_win_cnt: the 4-level nested counter (kc, kr, ocol, orow) with a wrap/last-tap/last-output flag.
// - conv_sched wraps conv_win_cnt with the FSM, the address registers and the 2-stage valid pipeline.
// TESTING (X=5, H=3 unless stated; cycle n = n-th rising edge after the one sampling start)
// - Basic sweep:
//   - First taps: addr_x 0,1,2,5,6,7,10,11,12 at cycles 1..9; addr_h 0..8.
//   - acc_first at cycle 2 only for position 0.
//   - First wr_en_y at cycle 11 with addr_y=0.
// - Full run: exactly 9 wr_en_y pulses, addr_y 0..8. Last write at cycle 83, done at cycle 84, busy low at cycle 85.
// - Position (1,2): first addr_x = 7, last addr_x = 19, addr_y = 5.
// - hold for 3 cycles mid-position: output sequence is identical to the unstalled run, shifted by 3 cycles; acc_en count stays 81.
// - reset asserted at cycle 40: all outputs 0 in the same cycle. A new start then runs a clean full sweep from addr_y=0.
// - H=1, X=4: 16 writes. Each position has one acc_en with acc_first set. addr_x = addr_y = 0..15. A start pulse during busy is ignored.

Source files
------------

// File: rtl/conv_pkg.sv
// conv_pkg: shared state encoding, address widths and geometry defaults for the conv sequencer
package conv_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    localparam int AW_X = 14;
    localparam int AW_H = 8;
    localparam int X_DEF = 5;
    localparam int H_DEF = 3;
    function automatic int out_dim(input int x, input int h);
        return x - h + 1;
    endfunction
endpackage

// File: rtl/conv_win_cnt.sv
// conv_win_cnt: nested window counter, kc fastest, then kr, ocol, orow
module conv_win_cnt
    import conv_pkg::*;
#(
    parameter int X = X_DEF,
    parameter int H = H_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clr,
    input  logic            en,
    output logic [AW_X-1:0] kc,
    output logic [AW_X-1:0] kr,
    output logic [AW_X-1:0] ocol,
    output logic [AW_X-1:0] orow,
    output logic            first_tap,
    output logic            last_tap,
    output logic            last_out
);
    localparam logic [AW_X-1:0] KM = AW_X'(H - 1);
    localparam logic [AW_X-1:0] OM = AW_X'(out_dim(X, H) - 1);

    assign first_tap = kc == '0 && kr == '0;
    assign last_tap  = kc == KM && kr == KM;
    assign last_out  = last_tap && ocol == OM && orow == OM;

    // step one tap per enabled cycle, wrapping each level into the next
    always_ff @(posedge clk or posedge reset) begin
        if (reset || clr) begin
            kc   <= '0;
            kr   <= '0;
            ocol <= '0;
            orow <= '0;
        end else if (en) begin
            kc   <= kc == KM ? '0 : kc + 1'b1;
            kr   <= kc != KM ? kr : kr == KM ? '0 : kr + 1'b1;
            ocol <= !last_tap ? ocol : ocol == OM ? '0 : ocol + 1'b1;
            orow <= !(last_tap && ocol == OM) ? orow : orow == OM ? '0 : orow + 1'b1;
        end
    end
endmodule

// File: rtl/conv_sched.sv
// conv_sched: sweeps every output position, issuing tap addresses and framing accumulate/commit
module conv_sched
    import conv_pkg::*;
#(
    parameter int X = X_DEF,
    parameter int H = H_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            hold,
    output logic            busy,
    output logic            done,
    output logic [AW_X-1:0] addr_x,
    output logic [AW_H-1:0] addr_h,
    output logic            acc_en,
    output logic            acc_first,
    output logic [AW_X-1:0] addr_y,
    output logic            wr_en_y
);
    localparam logic [AW_X-1:0] XW = AW_X'(X);
    localparam logic [AW_X-1:0] HW = AW_X'(H);
    localparam logic [AW_X-1:0] OW = AW_X'(out_dim(X, H));

    state_t state, nxt;
    logic [AW_X-1:0] kc, kr, ocol, orow, ah_full, iss_y, acc_y;
    logic first_tap, last_tap, last_out;
    logic iss_v, iss_first, iss_last, acc_q, acc_first_q, acc_last, wr_q;
    logic run;

    assign run     = state == RUN;
    assign busy    = state != IDLE;
    assign done    = state == DONE;
    assign ah_full = kr * HW + kc;
    assign acc_en    = acc_q & ~hold;
    assign acc_first = acc_first_q & ~hold;
    assign wr_en_y   = wr_q & ~hold;

    conv_win_cnt #(.X(X), .H(H)) u_cnt (
        .clk(clk), .reset(reset), .clr(state == IDLE), .en(run && !hold),
        .kc(kc), .kr(kr), .ocol(ocol), .orow(orow),
        .first_tap(first_tap), .last_tap(last_tap), .last_out(last_out)
    );

    // state register, frozen while hold is high
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else if (!hold)
            state <= nxt;
    end

    // next state: drain waits for the issue and accumulate stages to empty
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = start ? RUN : IDLE;
            RUN:     nxt = last_out ? DRAIN : RUN;
            DRAIN:   nxt = !iss_v && !acc_q ? DONE : DRAIN;
            default: nxt = IDLE;
        endcase
    end

    // issue -> accumulate -> commit pipeline; the one-stage offset covers memory read latency
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_x      <= '0;
            addr_h      <= '0;
            iss_v       <= 1'b0;
            iss_first   <= 1'b0;
            iss_last    <= 1'b0;
            iss_y       <= '0;
            acc_q       <= 1'b0;
            acc_first_q <= 1'b0;
            acc_last    <= 1'b0;
            acc_y       <= '0;
            wr_q        <= 1'b0;
            addr_y      <= '0;
        end else if (!hold) begin
            iss_v <= run;
            if (run) begin
                addr_x    <= (orow + kr) * XW + ocol + kc;
                addr_h    <= ah_full[AW_H-1:0];
                iss_first <= first_tap;
                iss_last  <= last_tap;
                iss_y     <= orow * OW + ocol;
            end
            acc_q       <= iss_v;
            acc_first_q <= iss_v & iss_first;
            acc_last    <= iss_v & iss_last;
            acc_y       <= iss_y;
            wr_q        <= acc_q & acc_last;
            if (acc_q && acc_last)
                addr_y <= acc_y;
        end
    end
endmodule

// File: tb/tb_conv_sched.sv
// tb_conv_sched: directed scenarios for the conv sweep sequencer (X=5,H=3 and X=4,H=1)
module tb_conv_sched;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start_a = 1'b0, hold_a = 1'b0, start_b = 1'b0, hold_b = 1'b0;
    logic busy_a, done_a, acc_en_a, acc_first_a, wr_en_y_a;
    logic busy_b, done_b, acc_en_b, acc_first_b, wr_en_y_b;
    logic [13:0] addr_x_a, addr_y_a, addr_x_b, addr_y_b;
    logic [7:0] addr_h_a, addr_h_b;

    int checks = 0;
    int failures = 0;
    int ax[0:127];
    int ah[0:127];
    int afst[0:127];
    int wr_cyc[0:31];
    int wr_adr[0:31];
    int nwr, nacc, nfirst, done_cyc, busy_low;
    int exp_ax[0:8] = '{0, 1, 2, 5, 6, 7, 10, 11, 12};

    always #5 clk = ~clk;

    conv_sched #(.X(5), .H(3)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .hold(hold_a),
        .busy(busy_a), .done(done_a), .addr_x(addr_x_a), .addr_h(addr_h_a),
        .acc_en(acc_en_a), .acc_first(acc_first_a), .addr_y(addr_y_a), .wr_en_y(wr_en_y_a)
    );

    conv_sched #(.X(4), .H(1)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .hold(hold_b),
        .busy(busy_b), .done(done_b), .addr_x(addr_x_b), .addr_h(addr_h_b),
        .acc_en(acc_en_b), .acc_first(acc_first_b), .addr_y(addr_y_b), .wr_en_y(wr_en_y_b)
    );

    task automatic sweep_a(input int ncyc, input int hold_at);
        nwr = 0; nacc = 0; nfirst = 0; done_cyc = -1; busy_low = -1;
        for (int i = 0; i < 32; i++) begin
            wr_cyc[i] = -1;
            wr_adr[i] = -1;
        end
        start_a = 1'b1;
        @(posedge clk);
        #1 start_a = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk);
            #1;
            ax[c] = int'(addr_x_a);
            ah[c] = int'(addr_h_a);
            afst[c] = int'(acc_first_a);
            if (acc_en_a) nacc++;
            if (acc_first_a) nfirst++;
            if (wr_en_y_a && nwr < 32) begin
                wr_cyc[nwr] = c;
                wr_adr[nwr] = int'(addr_y_a);
                nwr++;
            end
            if (done_a && done_cyc < 0) done_cyc = c;
            if (!busy_a && busy_low < 0) busy_low = c;
            if (c == hold_at) hold_a = 1'b1;
            if (c == hold_at + 3) hold_a = 1'b0;
        end
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if ({busy_a, done_a, addr_x_a, addr_h_a, acc_en_a, acc_first_a, addr_y_a, wr_en_y_a} !== '0) begin
            failures++;
            $display("FAIL reset_a outputs got=%0h exp=0", {busy_a, done_a, addr_x_a, addr_h_a, acc_en_a, acc_first_a, addr_y_a, wr_en_y_a});
        end
        checks++;
        if ({busy_b, done_b, addr_x_b, addr_h_b, acc_en_b, acc_first_b, addr_y_b, wr_en_y_b} !== '0) begin
            failures++;
            $display("FAIL reset_b outputs got=%0h exp=0", {busy_b, done_b, addr_x_b, addr_h_b, acc_en_b, acc_first_b, addr_y_b, wr_en_y_b});
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic;
        int fcount;
        sweep_a(90, -1);
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (ax[i+1] !== exp_ax[i]) begin
                failures++;
                $display("FAIL basic_addr_x cyc=%0d got=%0d exp=%0d", i + 1, ax[i+1], exp_ax[i]);
            end
            checks++;
            if (ah[i+1] !== i) begin
                failures++;
                $display("FAIL basic_addr_h cyc=%0d got=%0d exp=%0d", i + 1, ah[i+1], i);
            end
        end
        fcount = 0;
        for (int c = 1; c <= 10; c++) fcount += afst[c];
        checks++;
        if (afst[2] !== 1 || fcount !== 1) begin
            failures++;
            $display("FAIL basic_acc_first at2=%0d count=%0d exp=1,1", afst[2], fcount);
        end
        checks++;
        if (nwr !== 9) begin
            failures++;
            $display("FAIL basic_writes got=%0d exp=9", nwr);
        end
        for (int k = 0; k < 9; k++) begin
            checks++;
            if (wr_cyc[k] !== 11 + 9 * k || wr_adr[k] !== k) begin
                failures++;
                $display("FAIL basic_write%0d cyc=%0d addr=%0d exp cyc=%0d addr=%0d", k, wr_cyc[k], wr_adr[k], 11 + 9 * k, k);
            end
        end
        checks++;
        if (ax[46] !== 7 || ax[54] !== 19) begin
            failures++;
            $display("FAIL pos12_addr_x first=%0d last=%0d exp 7,19", ax[46], ax[54]);
        end
        checks++;
        if (done_cyc !== 84) begin
            failures++;
            $display("FAIL basic_done got=%0d exp=84", done_cyc);
        end
        checks++;
        if (busy_low !== 85) begin
            failures++;
            $display("FAIL basic_busy_low got=%0d exp=85", busy_low);
        end
        checks++;
        if (nacc !== 81 || nfirst !== 9) begin
            failures++;
            $display("FAIL basic_acc acc=%0d first=%0d exp 81,9", nacc, nfirst);
        end
    endtask

    task automatic test_hold;
        sweep_a(95, 20);
        checks++;
        if (nwr !== 9) begin
            failures++;
            $display("FAIL hold_writes got=%0d exp=9", nwr);
        end
        for (int k = 0; k < 9; k++) begin
            checks++;
            if (wr_cyc[k] !== (k < 2 ? 11 + 9 * k : 14 + 9 * k) || wr_adr[k] !== k) begin
                failures++;
                $display("FAIL hold_write%0d cyc=%0d addr=%0d exp cyc=%0d addr=%0d", k, wr_cyc[k], wr_adr[k], k < 2 ? 11 + 9 * k : 14 + 9 * k, k);
            end
        end
        checks++;
        if (nacc !== 81 || nfirst !== 9) begin
            failures++;
            $display("FAIL hold_acc acc=%0d first=%0d exp 81,9", nacc, nfirst);
        end
        checks++;
        if (done_cyc !== 87) begin
            failures++;
            $display("FAIL hold_done got=%0d exp=87", done_cyc);
        end
    endtask

    task automatic test_reset_mid;
        int stray;
        start_a = 1'b1;
        @(posedge clk);
        #1 start_a = 1'b0;
        repeat (40) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({busy_a, done_a, addr_x_a, addr_h_a, acc_en_a, acc_first_a, addr_y_a, wr_en_y_a} !== '0) begin
            failures++;
            $display("FAIL midreset_outputs got=%0h exp=0", {busy_a, done_a, addr_x_a, addr_h_a, acc_en_a, acc_first_a, addr_y_a, wr_en_y_a});
        end
        @(posedge clk);
        #1 reset = 1'b0;
        stray = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            if (wr_en_y_a || acc_en_a || busy_a) stray++;
        end
        checks++;
        if (stray !== 0) begin
            failures++;
            $display("FAIL midreset_quiet got=%0d exp=0", stray);
        end
        sweep_a(90, -1);
        checks++;
        if (nwr !== 9 || wr_cyc[0] !== 11 || wr_adr[0] !== 0 || wr_adr[8] !== 8) begin
            failures++;
            $display("FAIL midreset_resweep n=%0d c0=%0d a0=%0d a8=%0d exp 9,11,0,8", nwr, wr_cyc[0], wr_adr[0], wr_adr[8]);
        end
        checks++;
        if (done_cyc !== 84 || nacc !== 81) begin
            failures++;
            $display("FAIL midreset_done done=%0d acc=%0d exp 84,81", done_cyc, nacc);
        end
    endtask

    task automatic test_h1;
        int n_wr, n_acc, n_first, d_cyc;
        n_wr = 0; n_acc = 0; n_first = 0; d_cyc = -1;
        start_b = 1'b1;
        @(posedge clk);
        #1 start_b = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk);
            #1;
            if (c <= 16) begin
                checks++;
                if (int'(addr_x_b) !== c - 1) begin
                    failures++;
                    $display("FAIL h1_addr_x cyc=%0d got=%0d exp=%0d", c, addr_x_b, c - 1);
                end
            end
            if (acc_en_b) n_acc++;
            if (acc_en_b && acc_first_b) n_first++;
            if (wr_en_y_b) begin
                checks++;
                if (int'(addr_y_b) !== n_wr || c !== n_wr + 3) begin
                    failures++;
                    $display("FAIL h1_write%0d cyc=%0d addr=%0d exp cyc=%0d addr=%0d", n_wr, c, addr_y_b, n_wr + 3, n_wr);
                end
                n_wr++;
            end
            if (done_b && d_cyc < 0) d_cyc = c;
            start_b = (c == 5);
        end
        checks++;
        if (n_wr !== 16) begin
            failures++;
            $display("FAIL h1_writes got=%0d exp=16", n_wr);
        end
        checks++;
        if (n_acc !== 16 || n_first !== 16) begin
            failures++;
            $display("FAIL h1_acc acc=%0d first=%0d exp 16,16", n_acc, n_first);
        end
        checks++;
        if (d_cyc !== 19 || busy_b !== 1'b0) begin
            failures++;
            $display("FAIL h1_done cyc=%0d busy=%0d exp 19,0", d_cyc, busy_b);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_hold;
        test_reset_mid;
        test_h1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
